trade_order_ctrl: RTL and testbench

TRADE_ORDER_CTRL -- requirements
Module: trade_order_ctrl

---
 rtl/trade_order_ctrl.sv | 160 ++++++++++++++++
 tb/tb_trade_order_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trade_order_ctrl.sv
// -----------------------------------------------------------------------------
// trade_order_ctrl
// Turns buy/sell signals from the SMA signal stage into single-unit orders on a
// valid/ready interface. It tracks the signed net position against a +/-POS_LIMIT
// window and enforces a cooldown of COOLDOWN cycles after each completed order.
// All outputs are registered.
//
// Build option: define TRADE_ORDER_CTRL_STATS_EN to include the saturating
// reject counter. When the macro is not defined, rej_count is tied to zero.
// -----------------------------------------------------------------------------
module trade_order_ctrl #(
    parameter int POS_LIMIT = 4,    // 1..127
    parameter int COOLDOWN  = 8     // 0..255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sig_valid,
    input  logic              buy_signal,
    input  logic              sell_signal,
    input  logic              halt,
    input  logic              ord_ready,
    output logic              ord_valid,
    output logic              ord_side,
    output logic signed [7:0] position,
    output logic              busy,
    output logic [15:0]       rej_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    localparam logic signed [7:0] LIM_POS   = 8'(POS_LIMIT);
    localparam logic signed [7:0] LIM_NEG   = -LIM_POS;
    // The counter starts at COOLDOWN-1 and counts down to 0, so COOL lasts
    // exactly COOLDOWN cycles.
    localparam logic [7:0]        COOL_LOAD = 8'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

    state_t            r_state;
    logic [7:0]        r_cool_cnt;
    logic              r_ord_valid;
    logic              r_ord_side;
    logic signed [7:0] r_position;
    logic              r_busy;

    state_t            w_state_next;
    logic [7:0]        w_cool_next;
    logic              w_ord_valid_next;
    logic              w_ord_side_next;
    logic signed [7:0] w_position_next;

    // The request is qualified by sig_valid and halt. A request is "single"
    // when exactly one side is asserted.
    logic w_qual;
    logic w_buy_only;
    logic w_sell_only;
    logic w_buy_ok;
    logic w_sell_ok;

    assign w_qual      = sig_valid && !halt;
    assign w_buy_only  = buy_signal && !sell_signal;
    assign w_sell_only = sell_signal && !buy_signal;
    assign w_buy_ok    = (r_position < LIM_POS);
    assign w_sell_ok   = (r_position > LIM_NEG);

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cool_cnt  <= '0;
            r_ord_valid <= 1'b0;
            r_ord_side  <= 1'b0;
            r_position  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cool_cnt  <= w_cool_next;
            r_ord_valid <= w_ord_valid_next;
            r_ord_side  <= w_ord_side_next;
            r_position  <= w_position_next;
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    // Next-state logic: accept in IDLE, hold the order in ISSUE until the
    // handshake, then count down in COOL.
    always_comb begin
        w_state_next     = r_state;
        w_cool_next      = r_cool_cnt;
        w_ord_valid_next = r_ord_valid;
        w_ord_side_next  = r_ord_side;
        w_position_next  = r_position;
        case (r_state)
            S_IDLE: begin
                if (w_qual && ((w_buy_only && w_buy_ok) || (w_sell_only && w_sell_ok))) begin
                    w_state_next     = S_ISSUE;
                    w_ord_valid_next = 1'b1;
                    w_ord_side_next  = w_buy_only;
                end
            end
            S_ISSUE: begin
                // halt is deliberately ignored here: a presented order is never withdrawn.
                if (r_ord_valid && ord_ready) begin
                    w_ord_valid_next = 1'b0;
                    w_position_next  = r_ord_side ? (r_position + 8'sd1) : (r_position - 8'sd1);
                    if (COOLDOWN > 0) begin
                        w_state_next = S_COOL;
                        w_cool_next  = COOL_LOAD;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_COOL: begin
                if (r_cool_cnt == 8'd0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cool_next = r_cool_cnt - 8'd1;
                end
            end
            default: begin
                w_state_next     = S_IDLE;
                w_ord_valid_next = 1'b0;
            end
        endcase
    end

    assign ord_valid = r_ord_valid;
    assign ord_side  = r_ord_side;
    assign position  = r_position;
    assign busy      = r_busy;

`ifdef TRADE_ORDER_CTRL_STATS_EN
    // A reject is a qualified signal seen in IDLE that is either ambiguous
    // (both sides asserted) or fails the position limit check.
    logic        w_reject;
    logic [15:0] r_rej_count;

    assign w_reject = (r_state == S_IDLE) && w_qual &&
                      ((buy_signal && sell_signal) ||
                       (w_buy_only && !w_buy_ok) ||
                       (w_sell_only && !w_sell_ok));

    // Saturating reject counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rej_count <= '0;
        end else if (w_reject && (r_rej_count != 16'hFFFF)) begin
            r_rej_count <= r_rej_count + 16'd1;
        end
    end

    assign rej_count = r_rej_count;
`else
    assign rej_count = '0;
`endif

endmodule

// File: tb/tb_trade_order_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trade_order_ctrl
// Directed bench for trade_order_ctrl with POS_LIMIT=4 and COOLDOWN=8.
// Expected reject counts follow TRADE_ORDER_CTRL_STATS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_trade_order_ctrl;

`ifdef TRADE_ORDER_CTRL_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              sig_valid;
    logic              buy_signal;
    logic              sell_signal;
    logic              halt;
    logic              ord_ready;
    logic              ord_valid;
    logic              ord_side;
    logic signed [7:0] position;
    logic              busy;
    logic [15:0]       rej_count;

    int checks = 0;
    int errors = 0;

    trade_order_ctrl #(
        .POS_LIMIT (4),
        .COOLDOWN  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_valid   (sig_valid),
        .buy_signal  (buy_signal),
        .sell_signal (sell_signal),
        .halt        (halt),
        .ord_ready   (ord_ready),
        .ord_valid   (ord_valid),
        .ord_side    (ord_side),
        .position    (position),
        .busy        (busy),
        .rej_count   (rej_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One-cycle signal pulse with ord_ready=1. If accepted, the handshake and
    // the full cooldown are run through before returning in IDLE.
    task automatic try_sig(input bit is_buy, input bit exp_acc, input int exp_pos, input int exp_rej);
        sig_valid   = 1'b1;
        buy_signal  = is_buy;
        sell_signal = !is_buy;
        tick();
        sig_valid   = 1'b0;
        buy_signal  = 1'b0;
        sell_signal = 1'b0;
        chk("try_valid", 32'(ord_valid), 32'(exp_acc));
        if (exp_acc) begin
            chk("try_side", 32'(ord_side), 32'(is_buy));
            tick();
            chk("try_hs_valid", 32'(ord_valid), 0);
            repeat (8) tick();
        end
        chk("try_pos", $signed(position), exp_pos);
        chk("try_rej", 32'(rej_count), exp_rej);
        chk("try_idle", 32'(busy), 0);
        $display("txn buy=%0d accepted=%0d position=%0d rej_count=%0d", is_buy, ord_valid | busy | exp_acc, position, rej_count);
    endtask

    initial begin
        rst         = 1'b1;
        sig_valid   = 1'b0;
        buy_signal  = 1'b0;
        sell_signal = 1'b0;
        halt        = 1'b0;
        ord_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(ord_valid), 0);
        chk("rst_side",  32'(ord_side), 0);
        chk("rst_pos",   $signed(position), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_rej",   32'(rej_count), 0);

        // Buy with ord_ready=1: order at cycle 1, position 1 at cycle 2, idle at cycle 10
        ord_ready  = 1'b1;
        sig_valid  = 1'b1;
        buy_signal = 1'b1;
        tick();                                     // cycle 1
        sig_valid  = 1'b0;
        buy_signal = 1'b0;
        chk("buy_c1_valid", 32'(ord_valid), 1);
        chk("buy_c1_side",  32'(ord_side), 1);
        chk("buy_c1_busy",  32'(busy), 1);
        chk("buy_c1_pos",   $signed(position), 0);
        tick();                                     // cycle 2
        chk("buy_c2_valid", 32'(ord_valid), 0);
        chk("buy_c2_pos",   $signed(position), 1);
        chk("buy_c2_busy",  32'(busy), 1);
        $display("txn buy order completed position=%0d", position);
        tick(); tick(); tick();                     // cycle 5 (COOL)
        sig_valid  = 1'b1;                          // dropped during COOL
        buy_signal = 1'b1;
        tick();                                     // cycle 6
        sig_valid  = 1'b0;
        buy_signal = 1'b0;
        chk("cool_drop_valid", 32'(ord_valid), 0);
        chk("cool_drop_rej",   32'(rej_count), 0);
        tick(); tick(); tick();                     // cycle 9
        chk("cool_c9_busy",  32'(busy), 1);
        tick();                                     // cycle 10
        chk("cool_c10_busy", 32'(busy), 0);
        chk("cool_c10_pos",  $signed(position), 1);

        // Sell held off by ord_ready=0 for 5 cycles, halt raised mid-ISSUE
        do_reset();
        chk("rst2_pos", $signed(position), 0);
        ord_ready   = 1'b0;
        sig_valid   = 1'b1;
        sell_signal = 1'b1;
        tick();
        sig_valid   = 1'b0;
        sell_signal = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("sell_hold_valid", 32'(ord_valid), 1);
            chk("sell_hold_side",  32'(ord_side), 0);
            chk("sell_hold_pos",   $signed(position), 0);
            if (i == 2) halt = 1'b1;
            if (i < 4) tick();
        end
        ord_ready = 1'b1;
        tick();
        halt = 1'b0;
        chk("sell_hs_valid", 32'(ord_valid), 0);
        chk("sell_hs_pos",   $signed(position), -1);
        $display("txn sell order completed position=%0d", position);
        repeat (8) tick();
        chk("sell_idle_busy", 32'(busy), 0);

        // halt in IDLE: no order, no reject
        halt       = 1'b1;
        sig_valid  = 1'b1;
        buy_signal = 1'b1;
        tick();
        halt       = 1'b0;
        sig_valid  = 1'b0;
        buy_signal = 1'b0;
        chk("halt_valid", 32'(ord_valid), 0);
        chk("halt_busy",  32'(busy), 0);
        chk("halt_rej",   32'(rej_count), 0);
        $display("txn halted buy ignored rej_count=%0d", rej_count);

        // Both sides asserted: reject
        sig_valid   = 1'b1;
        buy_signal  = 1'b1;
        sell_signal = 1'b1;
        tick();
        buy_signal  = 1'b0;
        sell_signal = 1'b0;
        chk("both_valid", 32'(ord_valid), 0);
        chk("both_rej",   32'(rej_count), STATS);
        $display("txn both-sides reject rej_count=%0d", rej_count);

        // Neither side asserted: no-op
        tick();
        sig_valid = 1'b0;
        chk("none_valid", 32'(ord_valid), 0);
        chk("none_rej",   32'(rej_count), STATS);
        chk("none_pos",   $signed(position), -1);

        // Six buys against POS_LIMIT=4
        do_reset();
        try_sig(1'b1, 1'b1, 1, 0);
        try_sig(1'b1, 1'b1, 2, 0);
        try_sig(1'b1, 1'b1, 3, 0);
        try_sig(1'b1, 1'b1, 4, 0);
        try_sig(1'b1, 1'b0, 4, STATS);
        try_sig(1'b1, 1'b0, 4, 2 * STATS);

        // Sells down to -POS_LIMIT, then one more is rejected
        do_reset();
        try_sig(1'b0, 1'b1, -1, 0);
        try_sig(1'b0, 1'b1, -2, 0);
        try_sig(1'b0, 1'b1, -3, 0);
        try_sig(1'b0, 1'b1, -4, 0);
        try_sig(1'b0, 1'b0, -4, STATS);
        // A buy from the negative limit is still allowed
        try_sig(1'b1, 1'b1, -3, STATS);

        // Reset during ISSUE with position 3, coincident with the handshake
        do_reset();
        try_sig(1'b1, 1'b1, 1, 0);
        try_sig(1'b1, 1'b1, 2, 0);
        try_sig(1'b1, 1'b1, 3, 0);
        ord_ready  = 1'b0;
        sig_valid  = 1'b1;
        buy_signal = 1'b1;
        tick();
        sig_valid  = 1'b0;
        buy_signal = 1'b0;
        chk("pend_valid", 32'(ord_valid), 1);
        rst       = 1'b1;
        ord_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstiss_valid", 32'(ord_valid), 0);
        chk("rstiss_side",  32'(ord_side), 0);
        chk("rstiss_pos",   $signed(position), 0);
        chk("rstiss_busy",  32'(busy), 0);
        chk("rstiss_rej",   32'(rej_count), 0);
        $display("txn reset during ISSUE position=%0d", position);
        // Back in IDLE: the very next signal is accepted
        sig_valid   = 1'b1;
        sell_signal = 1'b1;
        tick();
        sig_valid   = 1'b0;
        sell_signal = 1'b0;
        chk("post_rst_valid", 32'(ord_valid), 1);
        chk("post_rst_side",  32'(ord_side), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
